// File: rtl/instr_fetch_decode_pkg.sv
// ISA definitions shared by the fetch/decode front end and the execute stage:
// opcodes, instruction field positions, front-end state encoding and decode record.
package cpu_isa_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 7;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_HALT
    } fd_state_e;

    typedef struct packed {
        logic [2:0]         opcode;
        logic [1:0]         rd;
        logic [1:0]         rs1;
        logic [1:0]         rs2;
        logic [INSTR_W-1:0] imm;
        logic               is_alu;
        logic               is_load;
        logic               is_store;
    } decoded_t;

    function automatic logic [INSTR_W-1:0] sext_imm9(input logic [8:0] v);
        return {{(INSTR_W-9){v[8]}}, v};
    endfunction

endpackage

// File: rtl/instr_fetch_decode_decoder.sv
// Combinational instruction decoder: splits an instruction word into register
// fields and the sign-extended offset, and classifies the opcode.
module instr_decoder
    import cpu_isa_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output logic [2:0]         opcode_o,
    output logic [1:0]         rd_o,
    output logic [1:0]         rs1_o,
    output logic [1:0]         rs2_o,
    output logic [INSTR_W-1:0] imm_o,
    output logic               is_alu_o,
    output logic               is_load_o,
    output logic               is_store_o,
    output logic               illegal_o
);

    assign opcode_o = ir_i[OPC_MSB:OPC_LSB];
    assign rd_o     = ir_i[RD_MSB:RD_LSB];
    assign rs1_o    = ir_i[RS1_MSB:RS1_LSB];
    assign rs2_o    = ir_i[RS2_MSB:RS2_LSB];
    assign imm_o    = sext_imm9(ir_i[IMM_MSB:IMM_LSB]);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        is_alu_o   = 1'b0;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_o)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: is_alu_o   = 1'b1;
            OP_LOAD:                        is_load_o  = 1'b1;
            OP_STORE:                       is_store_o = 1'b1;
            default:                        illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode front end: fetches one word per instruction from the shared
// memory port, decodes it and offers it to execute over a valid/ready handshake.
module instr_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_busy,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [2:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs1,
    output logic [1:0]         rs2,
    output logic [INSTR_W-1:0] imm,
    output logic               is_alu,
    output logic               is_load,
    output logic               is_store,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted
);

    fd_state_e          state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic [INSTR_W-1:0] ir_q;
    decoded_t           dec_q;
    decoded_t           dec_d;
    logic               illegal_d;
    logic               issue_valid_q;
    logic               halted_q;
    logic               fetch_go;

    instr_decoder u_decoder (
        .ir_i       (ir_q),
        .opcode_o   (dec_d.opcode),
        .rd_o       (dec_d.rd),
        .rs1_o      (dec_d.rs1),
        .rs2_o      (dec_d.rs2),
        .imm_o      (dec_d.imm),
        .is_alu_o   (dec_d.is_alu),
        .is_load_o  (dec_d.is_load),
        .is_store_o (dec_d.is_store),
        .illegal_o  (illegal_d)
    );

    // The memory samples the request mid-cycle, so the read strobe must follow mem_busy
    // within the same cycle rather than a clock later.
    assign fetch_go = (state_q == ST_FETCH) && !mem_busy;
    assign mem_rd   = fetch_go;
    assign mem_addr = fetch_go ? pc_q : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= '0;
            instr_pc_q    <= '0;
            ir_q          <= '0;
            dec_q         <= '0;
            issue_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!mem_busy) begin
                        ir_q       <= mem_rdata;
                        fetch_pc_q <= pc_q;
                        pc_q       <= pc_q + ADDR_W'(1);
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    dec_q      <= dec_d;
                    instr_pc_q <= fetch_pc_q;
                    if (illegal_d) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        issue_valid_q <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid_q <= 1'b0;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_valid = issue_valid_q;
    assign halted      = halted_q;
    assign opcode      = dec_q.opcode;
    assign rd          = dec_q.rd;
    assign rs1         = dec_q.rs1;
    assign rs2         = dec_q.rs2;
    assign imm         = dec_q.imm;
    assign is_alu      = dec_q.is_alu;
    assign is_load     = dec_q.is_load;
    assign is_store    = dec_q.is_store;
    assign instr_pc    = instr_pc_q;

endmodule
